// File: rtl/mem_access_unit.sv
// Load/store/fetch memory access unit: one outstanding request, lane steering and load extension.
// Optional build macro MEM_ACCESS_UNIT_MISALIGN_TRAP_EN answers misaligned requests without touching memory.
module mem_access_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_fetch,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_is_fetch,
  output logic              rsp_misaligned,
  output logic [XLEN-1:0]   rsp_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_R, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [2:0]        funct3_q;
  logic              write_q;
  logic              fetch_q;
  logic              mis_rsp;

  // Request decode: fetch is a word access; size code 11 is treated as word.
  logic [1:0]        size_in;
  logic              half_in;
  logic              word_in;
  logic [ADDR_W-1:0] addr_fix;

  assign size_in = req_is_fetch ? 2'b10 : req_funct3[1:0];
  assign half_in = (size_in == 2'b01);
  assign word_in = size_in[1];

  always_comb begin
    addr_fix = req_addr;
    if (half_in) addr_fix[0] = 1'b0;
    if (word_in) addr_fix[1:0] = 2'b00;
  end

`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
  logic mis_in;
  logic mis_q;
  assign mis_in  = (half_in & req_addr[0]) | (word_in & (req_addr[1:0] != 2'b00));
  assign mis_rsp = mis_q;
`else
  assign mis_rsp = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
          state_d = mis_in ? RESP : CMD;
`else
          state_d = CMD;
`endif
        end
      end
      CMD:     if (mem_gnt) state_d = write_q ? RESP : WAIT_R;
      WAIT_R:  if (mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture in IDLE, read data capture in WAIT_R
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      fetch_q  <= 1'b0;
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q   <= addr_fix;
        wdata_q  <= req_wdata;
        funct3_q <= req_is_fetch ? 3'b010 : req_funct3;
        write_q  <= req_write & ~req_is_fetch;
        fetch_q  <= req_is_fetch;
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
        mis_q    <= mis_in;
`endif
      end
      if (state_q == WAIT_R && mem_rvalid) rdata_q <= mem_rdata;
    end
  end

  // Lane steering for the command and the returned word
  logic [NB-1:0]    size_mask;
  logic [NB-1:0]    be_lane;
  logic [XLEN-1:0]  wdata_rep;
  logic [OFF_W+2:0] lane_sh;
  logic [XLEN-1:0]  lane;

  always_comb begin
    size_mask = NB'(15);
    wdata_rep = {(XLEN/32){wdata_q[31:0]}};
    case (funct3_q[1:0])
      2'b00: begin
        size_mask = NB'(1);
        wdata_rep = {NB{wdata_q[7:0]}};
      end
      2'b01: begin
        size_mask = NB'(3);
        wdata_rep = {(XLEN/16){wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign be_lane = size_mask << addr_q[OFF_W-1:0];
  assign lane_sh = {addr_q[OFF_W-1:0], 3'b000};
  assign lane    = rdata_q >> lane_sh;

  // Output decode from registered state and fields
  always_comb begin
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_is_fetch   = 1'b0;
    rsp_misaligned = 1'b0;
    rsp_data       = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_be         = '0;
    mem_wdata      = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      CMD: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
        mem_be    = be_lane;
        mem_wdata = wdata_rep;
      end
      RESP: begin
        rsp_valid      = 1'b1;
        rsp_is_fetch   = fetch_q;
        rsp_misaligned = mis_rsp;
        if (!write_q && !mis_rsp) begin
          case (funct3_q)
            3'b000:  rsp_data = XLEN'(signed'(lane[7:0]));
            3'b001:  rsp_data = XLEN'(signed'(lane[15:0]));
            3'b100:  rsp_data = XLEN'(lane[7:0]);
            3'b101:  rsp_data = XLEN'(lane[15:0]);
            3'b110:  rsp_data = XLEN'(lane[31:0]);
            default: rsp_data = XLEN'(signed'(lane[31:0]));
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (XLEN=32): directed table, random traffic against an arithmetic model,
// plus reset-abort and back-to-back fetch sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_fetch, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_is_fetch, rsp_misaligned;
  logic [31:0] rsp_data;
  logic        mem_req, mem_gnt, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_fetch(req_is_fetch), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_is_fetch(rsp_is_fetch),
    .rsp_misaligned(rsp_misaligned), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rsp;
    logic        mis;
    int          lat;
    int          reqc;
  } res_t;

  typedef struct {
    logic        fetch;
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    res_t        e;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic res_t mkres(logic [31:0] maddr, logic [3:0] be, logic [31:0] wd, logic we,
                                 logic [31:0] rsp, logic mis, int lat, int reqc);
    res_t r;
    r.maddr = maddr; r.be = be; r.wd = wd; r.we = we;
    r.rsp = rsp; r.mis = mis; r.lat = lat; r.reqc = reqc;
    return r;
  endfunction

  function automatic void add_vec(logic fetch, logic write, logic [2:0] f3, logic [31:0] addr,
                                  logic [31:0] wdata, logic [31:0] rdata, int gd, res_t e);
    vec_t v;
    v.fetch = fetch; v.write = write; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.gd = gd; v.e = e;
    vecs.push_back(v);
  endfunction

  // Reference: size in bytes, byte offset, and arithmetic extension of the selected bytes.
  function automatic res_t model(logic fetch, logic write, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] rdata, int gd);
    res_t e;
    int size;
    int off;
    bit uns;
    logic [31:0] a;
    longint unsigned v, lim;
    e = mkres(0, 0, 0, 0, 0, 0, 0, 0);
    size = fetch ? 4 : (f3[1:0] == 2'd0 ? 1 : (f3[1:0] == 2'd1 ? 2 : 4));
    uns  = !fetch && f3[2];
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
    if ((addr % size) != 0) begin
      e.mis = 1'b1; e.lat = 1; e.reqc = 0;
      return e;
    end
`endif
    a   = addr - (addr % size);
    off = int'(a % 4);
    e.maddr = a - off;
    e.be    = 4'(((1 << size) - 1) << off);
    e.we    = write;
    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    if (!write) begin
      lim = 64'd1 << (8 * size);
      v   = (64'(rdata) >> (8 * off)) % lim;
      if (!uns && v >= lim / 2) v = v - lim;
      e.rsp = 32'(v);
    end
    e.reqc = gd + 1;
    e.lat  = write ? gd + 2 : gd + 3;
    return e;
  endfunction

  // One request with a memory that grants after gd refused cycles and returns data a cycle later.
  task automatic run_txn(input logic fetch, input logic write, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gd, output res_t o, output logic stable, output logic rfetch);
    bit seen = 0, gprev = 0, done = 0;
    int cnt = 0;
    o = mkres(0, 0, 0, 0, 0, 0, -1, 0);
    stable = 1'b1;
    rfetch = 1'b0;
    chk("idle_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_is_fetch = fetch; req_write = write;
    req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      mem_rvalid = gprev;
      mem_rdata  = gprev ? rdata : ~rdata;
      gprev = 0;
      if (rsp_valid) begin
        o.rsp = rsp_data; o.mis = rsp_misaligned; rfetch = rsp_is_fetch;
        o.lat = cyc; done = 1;
      end else begin
        if (mem_req) begin
          if (!seen) begin
            o.maddr = mem_addr; o.be = mem_be; o.wd = mem_wdata; o.we = mem_we; seen = 1;
          end else if (mem_addr !== o.maddr || mem_be !== o.be || mem_wdata !== o.wd || mem_we !== o.we) begin
            stable = 1'b0;
          end
          cnt++;
          mem_gnt = (cnt > gd);
          gprev = mem_gnt && !write;
        end else begin
          mem_gnt = 1'b0;
        end
        @(negedge clk);
      end
    end
    o.reqc = cnt;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));
  endtask

  task automatic apply(input string tag, input vec_t v);
    res_t o;
    logic st, rf;
    run_txn(v.fetch, v.write, v.f3, v.addr, v.wdata, v.rdata, v.gd, o, st, rf);
    n_vec++;
    chk({tag, ".lat"},   64'(o.lat),   64'(v.e.lat));
    chk({tag, ".reqc"},  64'(o.reqc),  64'(v.e.reqc));
    chk({tag, ".maddr"}, 64'(o.maddr), 64'(v.e.maddr));
    chk({tag, ".be"},    64'(o.be),    64'(v.e.be));
    chk({tag, ".wdata"}, 64'(o.wd),    64'(v.e.wd));
    chk({tag, ".we"},    64'(o.we),    64'(v.e.we));
    chk({tag, ".rsp"},   64'(o.rsp),   64'(v.e.rsp));
    chk({tag, ".mis"},   64'(o.mis),   64'(v.e.mis));
    chk({tag, ".fetch"}, 64'(rf),      64'(v.fetch));
    chk({tag, ".stable"}, 64'(st),     64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    logic [31:0] pulses[$];
    logic [2:0]  ld_codes[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int idx;
    bit hs, gprev;
    logic [31:0] gaddr;

    reset = 1'b1; req_valid = 0; req_is_fetch = 0; req_write = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    n_vec++;
    chk("rst.req_ready", 64'(req_ready), 64'(1));
    chk("rst.mem_req",   64'(mem_req),   64'(0));
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst.outs", 64'({mem_be, mem_we, rsp_is_fetch, rsp_misaligned}), 64'(0));
    chk("rst.mem_addr",  64'(mem_addr),  64'(0));
    chk("rst.rsp_data",  64'(rsp_data),  64'(0));
    reset = 1'b0;
    @(negedge clk);

    add_vec(0, 0, 3'b010, 32'h100, 32'h0, 32'h8000_00FF, 3, mkres(32'h100, 4'hF, 0, 0, 32'h8000_00FF, 0, 6, 4));
    add_vec(0, 0, 3'b000, 32'h103, 32'h0, 32'h80AA_BBCC, 0, mkres(32'h100, 4'h8, 0, 0, 32'hFFFF_FF80, 0, 3, 1));
    add_vec(0, 0, 3'b100, 32'h103, 32'h0, 32'h80AA_BBCC, 0, mkres(32'h100, 4'h8, 0, 0, 32'h0000_0080, 0, 3, 1));
    add_vec(0, 0, 3'b101, 32'h102, 32'h0, 32'h80AA_BBCC, 0, mkres(32'h100, 4'hC, 0, 0, 32'h0000_80AA, 0, 3, 1));
    add_vec(0, 1, 3'b001, 32'h206, 32'h1234_ABCD, 32'h0, 0, mkres(32'h204, 4'hC, 32'hABCD_ABCD, 1, 0, 0, 2, 1));
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
    add_vec(0, 0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 0, mkres(0, 0, 0, 0, 0, 1, 1, 0));
`else
    add_vec(0, 0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 0, mkres(32'h100, 4'hF, 0, 0, 32'hCAFE_F00D, 0, 3, 1));
`endif
    add_vec(0, 1, 3'b000, 32'h101, 32'h0000_0055, 32'h0, 0, mkres(32'h100, 4'h2, 32'h5555_5555, 1, 0, 0, 2, 1));
    add_vec(1, 0, 3'b000, 32'h008, 32'h0, 32'h0000_0013, 0, mkres(32'h008, 4'hF, 0, 0, 32'h0000_0013, 0, 3, 1));
    add_vec(0, 0, 3'b001, 32'h100, 32'h0, 32'h1234_8001, 1, mkres(32'h100, 4'h3, 0, 0, 32'hFFFF_8001, 0, 4, 2));
    add_vec(0, 0, 3'b001, 32'h102, 32'h0, 32'h7FFF_1234, 0, mkres(32'h100, 4'hC, 0, 0, 32'h0000_7FFF, 0, 3, 1));
    add_vec(0, 1, 3'b010, 32'h010, 32'hDEAD_BEEF, 32'h0, 2, mkres(32'h010, 4'hF, 32'hDEAD_BEEF, 1, 0, 0, 4, 3));

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    for (int k = 0; k < 60; k++) begin
      rv.write = ($urandom_range(0, 2) == 0);
      rv.fetch = !rv.write && ($urandom_range(0, 4) == 0);
      rv.f3    = rv.write ? ld_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
      rv.addr  = 32'($urandom_range(0, 4095));
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.gd    = $urandom_range(0, 2);
      rv.e     = model(rv.fetch, rv.write, rv.f3, rv.addr, rv.wdata, rv.rdata, rv.gd);
      apply($sformatf("rnd%0d", k), rv);
    end

    // Reset while the command is pending, then while waiting for read data
    n_vec++;
    req_valid = 1; req_is_fetch = 0; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 0;
    chk("rstcmd.mem_req_before", 64'(mem_req), 64'(1));
    reset = 1'b1;
    #1;
    chk("rstcmd.mem_req", 64'(mem_req), 64'(0));
    chk("rstcmd.req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h80;
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("rstwait.busy", 64'({req_ready, mem_req}), 64'(0));
    reset = 1'b1;
    #1;
    chk("rstwait.mem_req", 64'(mem_req), 64'(0));
    chk("rstwait.req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    idx = 0;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) idx++;
    end
    mem_rvalid = 0;
    chk("rstwait.no_rsp", 64'(idx), 64'(0));
    chk("rstwait.idle", 64'(req_ready), 64'(1));

    // Three fetches with req_valid held high
    n_vec++;
    idx = 0; hs = 0; gprev = 0; gaddr = 0;
    req_valid = 1; req_is_fetch = 1; req_write = 0; req_funct3 = 3'b000; req_addr = 32'h0;
    for (int c = 0; c < 24; c++) begin
      if (hs) begin
        idx++;
        if (idx == 3) req_valid = 0;
        else req_addr = 32'(idx * 4);
      end
      mem_rvalid = gprev;
      mem_rdata  = gprev ? (32'hA000_0000 | gaddr) : 32'h0;
      gprev = 0;
      if (rsp_valid) begin
        pulses.push_back(rsp_data);
        chk("b2b.rsp_is_fetch", 64'(rsp_is_fetch), 64'(1));
      end
      if (mem_req) begin
        mem_gnt = 1; gprev = 1; gaddr = mem_addr;
      end else begin
        mem_gnt = 0;
      end
      hs = req_valid && req_ready;
      @(negedge clk);
    end
    mem_gnt = 0; mem_rvalid = 0;
    chk("b2b.count", 64'(pulses.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < pulses.size()) chk($sformatf("b2b.data%0d", i), 64'(pulses[i]), 64'(32'hA000_0000 | 32'(i * 4)));
      else chk($sformatf("b2b.missing%0d", i), 64'(0), 64'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
